present_key_unschedule: RTL

Reverse-direction key schedule for the PRESENT-80 decryption datapath. It accepts either the master key K_0 or the final schedule state K_N, and then streams the key states K_N, K_(N-1), ..., K_0 one per accepted beat, so the inverse round logic can consume round keys last-to-first. When given K_0, it first runs the forward schedule internally for N cycles, then runs the exact inverse of each update step.

---
 rtl/present_key_unschedule.sv | 119 +++++++++++
 1 files changed

// File: rtl/present_key_unschedule.sv
// PRESENT-80 reverse key schedule: streams K_N down to K_0 for the decryption
// datapath. A master key is first rolled forward N steps; a supplied K_N is
// streamed directly. Each accepted beat applies one inverse update step.
module present_key_unschedule #(
  parameter int LAST_ROUND = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [79:0] key_in,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [79:0] key_out,
  output logic [63:0] round_key,
  output logic [4:0]  round_out,
  output logic        out_last,
  output logic        busy
);

  localparam logic [4:0] N = LAST_ROUND[4:0];

  typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;

  state_t      state;
  logic [79:0] key_p0;
  logic [4:0]  cnt_p0;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  // K_c from K_(c-1): rotate right by 19, S-box top nibble, mix in counter.
  function automatic logic [79:0] fwd_step(input logic [79:0] k, input logic [4:0] c);
    logic [79:0] t;
    t = {k[18:0], k[79:19]};
    t[79:76] = sbox(t[79:76]);
    t[19:15] = t[19:15] ^ c;
    return t;
  endfunction

  // K_(c-1) from K_c: undo the counter mix and S-box, then rotate left by 19.
  function automatic logic [79:0] inv_step(input logic [79:0] k, input logic [4:0] c);
    logic [79:0] t;
    t = k;
    t[19:15] = t[19:15] ^ c;
    t[79:76] = sbox_inv(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction

  // Control FSM plus key/counter state; outputs are decoded from these registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      key_p0 <= '0;
      cnt_p0 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            key_p0 <= key_in;
            if (mode) begin
              cnt_p0 <= N;
              state  <= EMIT;
            end else begin
              cnt_p0 <= 5'd1;
              state  <= FWD;
            end
          end
        end
        FWD: begin
          key_p0 <= fwd_step(key_p0, cnt_p0);
          if (cnt_p0 == N) begin
            state <= EMIT;
          end else begin
            cnt_p0 <= cnt_p0 + 5'd1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (cnt_p0 != 5'd0) begin
              key_p0 <= inv_step(key_p0, cnt_p0);
              cnt_p0 <= cnt_p0 - 5'd1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == EMIT);
  assign out_last  = (state == EMIT) && (cnt_p0 == 5'd0);
  assign busy      = (state != IDLE);
  assign key_out   = key_p0;
  assign round_key = key_p0[79:16];
  assign round_out = cnt_p0;

endmodule
